regfile_write_queue: RTL and testbench



---
 rtl/regwb_pkg.sv | 11 +
 rtl/regwb_fifo.sv | 63 ++++++
 rtl/regwb_write_queue.sv | 1 +
 rtl/regfile_write_queue.sv | 91 +++++++++
 tb/tb_regfile_write_queue.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/regwb_pkg.sv
// regwb_pkg: shared widths and the queued write-back entry type.
package regwb_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regwb_fifo.sv
// regwb_fifo: circular buffer of write-back entries with two ordered push ports and one pop.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         push_a,
    input  wb_entry_t                    din_a,
    input  logic                         push_b,
    input  wb_entry_t                    din_b,
    input  logic                         pop,
    output wb_entry_t                    head,
    output logic [CW-1:0]                count,
    output logic                         empty,
    output logic [DEPTH-1:0]             slot_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] slot_reg
);
    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Port a always lands ahead of port b when both push in the same cycle.
    always_comb begin
        mem_d = mem_q;
        if (push_a) mem_d[wr_ptr_q] = din_a;
        if (push_b) mem_d[push_a ? wr_ptr_q + PW'(1) : wr_ptr_q] = din_b;
        wr_ptr_d = wr_ptr_q + PW'(push_a) + PW'(push_b);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = CW'(PW'(i) - rd_ptr_q) < count_q;
            slot_reg[i]   = mem_q[i].rd;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = count_q == '0;
endmodule

// File: rtl/regwb_write_queue.sv
// regwb_write_queue: no module here; the top level is regfile_write_queue in regfile_write_queue.sv.

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: arbitrates ALU/load write-backs into an in-order queue, issues one
// register-file write per cycle and exports a pending-write scoreboard.
module regfile_write_queue
    import regwb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = regwb_pkg::DATA_W,
    parameter int ADDR_W = regwb_pkg::ADDR_W,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              regWrite,
    output logic [31:0]       pending,
    output logic              idle
);
    wb_entry_t                    head;
    logic [CW-1:0]                count;
    logic                         empty, pop, mem_nz, push_a, push_b;
    logic [DEPTH-1:0]             slot_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] slot_reg;
    logic [ADDR_W-1:0]            write_reg_q, write_reg_d;
    logic [DATA_W-1:0]            write_data_q, write_data_d;
    logic                         reg_write_q, reg_write_d;

    // Readies ignore the same-cycle pop, and alu only counts a mem request that will occupy a slot.
    always_comb begin
        mem_nz    = mem_valid && mem_reg != ZERO_REG;
        mem_ready = !reset && count < CW'(DEPTH);
        alu_ready = !reset && ({1'b0, count} + (CW+1)'(mem_nz)) < (CW+1)'(DEPTH);
        push_a    = mem_nz && mem_ready;
        push_b    = alu_valid && alu_ready && alu_reg != ZERO_REG;
        pop       = !empty;
    end

    regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK        (CLK),
        .reset      (reset),
        .push_a     (push_a),
        .din_a      ('{rd: mem_reg, data: mem_data}),
        .push_b     (push_b),
        .din_b      ('{rd: alu_reg, data: alu_data}),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .empty      (empty),
        .slot_valid (slot_valid),
        .slot_reg   (slot_reg)
    );

    always_comb begin
        reg_write_d  = pop;
        write_reg_d  = pop ? head.rd : write_reg_q;
        write_data_d = pop ? head.data : write_data_q;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (slot_valid[i]) pending = pending | (32'(1) << slot_reg[i]);
        if (reg_write_q) pending = pending | (32'(1) << write_reg_q);
        pending[0] = 1'b0;
    end

    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign regWrite  = reg_write_q;
    assign idle      = empty && !reg_write_q;
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed steps with a scoreboard of expected register-file writes.
module tb_regfile_write_queue;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0, alu_valid = 1'b0;
    logic [4:0]  mem_reg = '0, alu_reg = '0;
    logic [31:0] mem_data = '0, alu_data = '0;
    logic        mem_ready, alu_ready, regWrite, idle;
    logic [4:0]  writeReg;
    logic [31:0] writeData, pending;

    int n_cmp = 0, n_err = 0, mcount = 0;
    logic [36:0] sb [$];

    regfile_write_queue dut (
        .CLK(CLK), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .pending(pending), .idle(idle)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every issued write must match the oldest outstanding expected write.
    always @(negedge CLK) begin
        if (regWrite === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_write: observed reg %0d data %h expected no write", writeReg, writeData);
            end else begin
                check("issue", {27'b0, writeReg, writeData}, {27'b0, sb.pop_front()});
            end
        end
    end

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        output logic ma, output logic aa);
        logic em, ea;
        int pushes;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        #1;
        em = mcount < 4;
        ea = (mcount + ((mv && mr != 0) ? 1 : 0)) < 4;
        check("mem_ready", 64'(mem_ready), 64'(em));
        check("alu_ready", 64'(alu_ready), 64'(ea));
        ma = mv && em;
        aa = av && ea;
        pushes = 0;
        if (ma && mr != 0) begin sb.push_back({mr, md}); pushes++; end
        if (aa && ar != 0) begin sb.push_back({ar, ad}); pushes++; end
        mcount = mcount + pushes - (mcount > 0 ? 1 : 0);
        @(negedge CLK);
        #1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        logic ma, aa;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ma, aa);
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || idle !== 1'b1) && k < 30) begin
            idle_cycle();
            k++;
        end
        check("drain_done", 64'(sb.size() == 0 && idle === 1'b1), 64'd1);
    endtask

    initial begin
        logic ma, aa;
        int mi, ai;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_regWrite", 64'(regWrite), 64'd0);
        check("rst_writeReg", 64'(writeReg), 64'd0);
        check("rst_writeData", 64'(writeData), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_mem_ready", 64'(mem_ready), 64'd1);
        check("post_rst_alu_ready", 64'(alu_ready), 64'd1);

        // single ALU write and its pending window
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'hFFFF0000, ma, aa);
        check("single_wait_regWrite", 64'(regWrite), 64'd0);
        check("single_pending_queued", 64'(pending), 64'(32'h1 << 21));
        idle_cycle();
        check("single_regWrite", 64'(regWrite), 64'd1);
        check("single_pending_issuing", 64'(pending), 64'(32'h1 << 21));
        idle_cycle();
        check("single_pending_clear", 64'(pending), 64'd0);
        check("single_idle", 64'(idle), 64'd1);

        // dual same-cycle: mem first, then alu
        step(1'b1, 5'd10, 32'h0000FFFF, 1'b1, 5'd21, 32'hFFFF0000, ma, aa);
        check("dual_pending", 64'(pending), 64'((32'h1 << 10) | (32'h1 << 21)));
        drain();

        // $0 requests are accepted but vanish
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEADBEEF, ma, aa);
        check("zero_accepted", 64'(aa), 64'd1);
        for (int i = 0; i < 2; i++) begin
            check("zero_regWrite", 64'(regWrite), 64'd0);
            check("zero_pending", 64'(pending), 64'd0);
            check("zero_idle", 64'(idle), 64'd1);
            idle_cycle();
        end

        // sustained dual-port pressure, producers hold a request until it is taken
        mi = 0;
        ai = 0;
        for (int c = 0; c < 6; c++) begin
            step(mi < 6, 5'(2 * mi + 1), 32'h100 + 32'(mi), ai < 6, 5'(2 * ai + 2), 32'h200 + 32'(ai), ma, aa);
            if (ma) mi++;
            if (aa) ai++;
        end
        check("fill_alu_stalled", 64'(ai < 6), 64'd1);
        drain();

        // same-register overwrite
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd1, ma, aa);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd2, ma, aa);
        check("ovw_pending_first", 64'(pending[5]), 64'd1);
        idle_cycle();
        check("ovw_pending_second", 64'(pending[5]), 64'd1);
        check("ovw_second_issuing", 64'(regWrite), 64'd1);
        idle_cycle();
        check("ovw_pending_clear", 64'(pending[5]), 64'd0);
        drain();

        // reset mid-operation drops everything queued
        step(1'b1, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8, ma, aa);
        step(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA, ma, aa);
        reset = 1'b1;
        mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'h33;
        alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h44;
        #1;
        check("midrst_mem_ready", 64'(mem_ready), 64'd0);
        check("midrst_alu_ready", 64'(alu_ready), 64'd0);
        sb.delete();
        mcount = 0;
        @(negedge CLK);
        #1;
        check("midrst_regWrite", 64'(regWrite), 64'd0);
        check("midrst_pending", 64'(pending), 64'd0);
        check("midrst_idle", 64'(idle), 64'd1);
        check("midrst_writeReg", 64'(writeReg), 64'd0);
        reset = 1'b0;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        repeat (6) idle_cycle();
        check("midrst_still_idle", 64'(idle), 64'd1);
        check("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
